// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// A holder keeps the resource until it drops its request or has held it for
// MAX_HOLD consecutive cycles. On release, the next holder is chosen by a circular
// scan that starts just after the previous holder.
module rr_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CW       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req_i,
   output logic [3:0] grant_o,
   output logic [1:0] grant_idx_o,
   output logic       grant_valid_o
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e        state_q, state_d;
   logic [1:0]    grant_idx_q, grant_idx_d;
   logic [1:0]    last_idx_q, last_idx_d;
   logic [CW-1:0] hold_cnt_q, hold_cnt_d;

   // Circular scan from base+1 through base. The loop runs from the farthest offset
   // down to the nearest, so the nearest requester is written last and wins.
   // An offset of 4 wraps to base itself.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
      logic [1:0] sel;
      logic [1:0] cand;
      sel = base;
      for (int k = 4; k >= 1; k--) begin
         cand = base + 2'(k);
         if (r[cand]) sel = cand;
      end
      return sel;
   endfunction

   // Next-state logic: start a grant, keep it, or release and re-arbitrate.
   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      last_idx_d  = last_idx_q;
      hold_cnt_d  = hold_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_i != 4'b0000) begin
               grant_idx_d = pick(req_i, last_idx_q);
               hold_cnt_d  = CW'(1);
               state_d     = StGrant;
            end
         end
         StGrant: begin
            if (req_i[grant_idx_q] && (hold_cnt_q < CW'(MAX_HOLD))) begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end else begin
               // Release: the current holder becomes the scan origin.
               last_idx_d = grant_idx_q;
               if (req_i != 4'b0000) begin
                  grant_idx_d = pick(req_i, grant_idx_q);
                  hold_cnt_d  = CW'(1);
               end else begin
                  hold_cnt_d = '0;
                  state_d    = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; last_idx resets to 3 so requester 0 is scanned first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         grant_idx_q <= 2'b00;
         last_idx_q  <= 2'b11;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         last_idx_q  <= last_idx_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   // Outputs: 2-to-4 decode of the holder index, gated by the grant state.
   always_comb begin
      grant_valid_o = (state_q == StGrant);
      grant_idx_o   = grant_idx_q;
      grant_o       = 4'b0000;
      if (grant_valid_o) begin
         unique case (grant_idx_q)
            2'd0: grant_o = 4'b0001;
            2'd1: grant_o = 4'b0010;
            2'd2: grant_o = 4'b0100;
            2'd3: grant_o = 4'b1000;
            default: grant_o = 4'b0000;
         endcase
      end
   end

endmodule
